xif_result_scoreboard: RTL and testbench



---
 rtl/xif_result_scoreboard_if.sv | 57 +++++
 rtl/xif_result_scoreboard.sv | 260 ++++++++++++++++++++++++++
 tb/tb_xif_result_scoreboard.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xif_result_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : xif_result_scoreboard_if
// Description : Snoop bundle for the XIF result scoreboard. Carries both
//               coprocessor result handshakes (A = fpu_ss, B = rvfpm) into the
//               checker and its status back out.
// Revision    : 1.0 - initial release
// ============================================================================
interface xif_result_scoreboard_if #(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    // Side A result handshake
    logic                  a_valid_i;
    logic                  a_ready_i;
    logic [ID_WIDTH-1:0]   a_id_i;
    logic                  a_we_i;
    logic [4:0]            a_rd_i;
    logic [DATA_WIDTH-1:0] a_data_i;

    // Side B result handshake
    logic                  b_valid_i;
    logic                  b_ready_i;
    logic [ID_WIDTH-1:0]   b_id_i;
    logic                  b_we_i;
    logic [4:0]            b_rd_i;
    logic [DATA_WIDTH-1:0] b_data_i;

    // Checker status
    logic                  mismatch_o;
    logic [ID_WIDTH-1:0]   mismatch_id_o;
    logic                  dup_err_o;
    logic                  timeout_o;
    logic                  err_o;
    logic [CNT_WIDTH-1:0]  match_cnt_o;
    logic [CNT_WIDTH-1:0]  mismatch_cnt_o;
    logic [CNT_WIDTH-1:0]  timeout_cnt_o;
    logic [ID_WIDTH:0]     pending_o;

    // Environment side: drives the snooped results, observes the status
    modport master (
        output a_valid_i, a_ready_i, a_id_i, a_we_i, a_rd_i, a_data_i,
        output b_valid_i, b_ready_i, b_id_i, b_we_i, b_rd_i, b_data_i,
        input  mismatch_o, mismatch_id_o, dup_err_o, timeout_o, err_o,
        input  match_cnt_o, mismatch_cnt_o, timeout_cnt_o, pending_o
    );

    // Checker side
    modport slave (
        input  a_valid_i, a_ready_i, a_id_i, a_we_i, a_rd_i, a_data_i,
        input  b_valid_i, b_ready_i, b_id_i, b_we_i, b_rd_i, b_data_i,
        output mismatch_o, mismatch_id_o, dup_err_o, timeout_o, err_o,
        output match_cnt_o, mismatch_cnt_o, timeout_cnt_o, pending_o
    );
endinterface
`default_nettype wire

// File: rtl/xif_result_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : xif_result_scoreboard
// Description : Passive shadow checker for two XIF coprocessors. Results are
//               matched by instruction id out of order, writeback fields are
//               compared, and mismatches, duplicate results and partners that
//               never arrive (timeouts) are flagged and counted.
// Revision    : 1.0 - initial release
// ============================================================================
module xif_result_scoreboard #(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 256,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    xif_result_scoreboard_if.slave  bus
);

    localparam int c_ENTRIES = 2 ** ID_WIDTH;
    localparam int c_AGE_W   = $clog2(TIMEOUT);
    localparam int c_SUM_W   = CNT_WIDTH + ID_WIDTH + 1;

    // The capture cycle counts as age 0, so the stored age is 1 one cycle later
    // and the entry expires in the cycle where it reads TIMEOUT-1.
    localparam logic [c_AGE_W-1:0] c_AGE_FIRST = c_AGE_W'(1);
    localparam logic [c_AGE_W-1:0] c_AGE_LAST  = c_AGE_W'(TIMEOUT - 1);
    localparam logic [c_SUM_W-1:0] c_CNT_MAX   = c_SUM_W'({CNT_WIDTH{1'b1}});

    localparam logic c_SIDE_A = 1'b0;
    localparam logic c_SIDE_B = 1'b1;

    // ------------------------------------------------------------------------
    // Entry storage, indexed by instruction id
    // ------------------------------------------------------------------------
    logic [c_ENTRIES-1:0]  r_busy;
    logic [c_ENTRIES-1:0]  r_side;
    logic [c_ENTRIES-1:0]  r_we;
    logic [4:0]            r_rd   [c_ENTRIES];
    logic [DATA_WIDTH-1:0] r_data [c_ENTRIES];
    logic [c_AGE_W-1:0]    r_age  [c_ENTRIES];

    // Registered outputs
    logic                  r_mismatch;
    logic [ID_WIDTH-1:0]   r_mismatch_id;
    logic                  r_dup;
    logic                  r_timeout;
    logic                  r_err;
    logic [CNT_WIDTH-1:0]  r_match_cnt;
    logic [CNT_WIDTH-1:0]  r_mismatch_cnt;
    logic [CNT_WIDTH-1:0]  r_timeout_cnt;
    logic [ID_WIDTH:0]     r_pending;

    // ------------------------------------------------------------------------
    // Arrival decode
    // ------------------------------------------------------------------------
    logic                  w_a_fire;
    logic                  w_b_fire;
    logic                  w_same;
    logic                  w_a_busy;
    logic                  w_a_side;
    logic                  w_b_busy;
    logic                  w_b_side;
    logic                  w_a_direct;
    logic                  w_cmp_a;
    logic                  w_cmp_b;
    logic                  w_eq_a;
    logic                  w_eq_b;
    logic                  w_ok_a;
    logic                  w_ok_b;
    logic                  w_mm_a;
    logic                  w_mm_b;
    logic                  w_dup_a;
    logic                  w_dup_b;
    logic                  w_wr_a;
    logic                  w_wr_b;
    logic                  w_ref_we;
    logic [4:0]            w_ref_rd;
    logic [DATA_WIDTH-1:0] w_ref_data;
    logic [c_ENTRIES-1:0]  w_hit;
    logic [c_ENTRIES-1:0]  w_to;
    logic [c_ENTRIES-1:0]  w_busy_nxt;
    logic [ID_WIDTH:0]     w_to_cnt;
    logic [ID_WIDTH:0]     w_pend_nxt;
    logic [1:0]            w_match_inc;
    logic [1:0]            w_mismatch_inc;

    // Writeback fields agree when both write or both skip, and a write also
    // agrees on destination and data.
    function automatic logic results_agree(
        input logic                  we_x,
        input logic [4:0]            rd_x,
        input logic [DATA_WIDTH-1:0] data_x,
        input logic                  we_y,
        input logic [4:0]            rd_y,
        input logic [DATA_WIDTH-1:0] data_y
    );
        return (we_x == we_y) && (!we_x || ((rd_x == rd_y) && (data_x == data_y)));
    endfunction

    // Counter add that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_add(
        input logic [CNT_WIDTH-1:0] cnt,
        input logic [ID_WIDTH:0]    inc
    );
        logic [c_SUM_W-1:0] sum;
        sum = c_SUM_W'(cnt) + c_SUM_W'(inc);
        if (sum > c_CNT_MAX) begin
            return {CNT_WIDTH{1'b1}};
        end
        return sum[CNT_WIDTH-1:0];
    endfunction

    // Classify this cycle's arrivals against the entries they address.
    always_comb begin
        w_a_fire = bus.a_valid_i & bus.a_ready_i;
        w_b_fire = bus.b_valid_i & bus.b_ready_i;
        w_same   = w_a_fire & w_b_fire & (bus.a_id_i == bus.b_id_i);

        w_a_busy = r_busy[bus.a_id_i];
        w_a_side = r_side[bus.a_id_i];
        w_b_busy = r_busy[bus.b_id_i];
        w_b_side = r_side[bus.b_id_i];

        // Both sides deliver the same free id together: compare them directly
        // and never allocate the entry. This compare is credited to side A.
        w_a_direct = w_same & ~w_a_busy;

        // Side A compare: against a pending B result, or the direct pairing.
        w_cmp_a    = w_a_fire & ((w_a_busy & (w_a_side == c_SIDE_B)) | w_a_direct);
        w_ref_we   = w_a_direct ? bus.b_we_i   : r_we[bus.a_id_i];
        w_ref_rd   = w_a_direct ? bus.b_rd_i   : r_rd[bus.a_id_i];
        w_ref_data = w_a_direct ? bus.b_data_i : r_data[bus.a_id_i];
        w_eq_a     = results_agree(bus.a_we_i, bus.a_rd_i, bus.a_data_i,
                                   w_ref_we, w_ref_rd, w_ref_data);

        // Side B compare: only ever against a pending A result.
        w_cmp_b = w_b_fire & w_b_busy & (w_b_side == c_SIDE_A);
        w_eq_b  = results_agree(bus.b_we_i, bus.b_rd_i, bus.b_data_i,
                                r_we[bus.b_id_i], r_rd[bus.b_id_i], r_data[bus.b_id_i]);

        w_ok_a = w_cmp_a & w_eq_a;
        w_mm_a = w_cmp_a & ~w_eq_a;
        w_ok_b = w_cmp_b & w_eq_b;
        w_mm_b = w_cmp_b & ~w_eq_b;

        // Same side re-delivering a pending id. In a same-id pairing cycle the
        // stored copy is consumed by the other side, so that is not a duplicate.
        w_dup_a = w_a_fire & w_a_busy & (w_a_side == c_SIDE_A) & ~w_same;
        w_dup_b = w_b_fire & w_b_busy & (w_b_side == c_SIDE_B) & ~w_same;

        // A result is stored unless it is consumed by a compare this cycle.
        w_wr_a = w_a_fire & ~(w_a_busy & (w_a_side == c_SIDE_B)) & ~w_a_direct;
        w_wr_b = w_b_fire & ~(w_b_busy & (w_b_side == c_SIDE_A)) & ~(w_same & ~w_b_busy);

        w_match_inc    = {1'b0, w_ok_a} + {1'b0, w_ok_b};
        w_mismatch_inc = {1'b0, w_mm_a} + {1'b0, w_mm_b};
    end

    // Per-entry hit and expiry: an arrival for an id always beats its timeout.
    always_comb begin
        w_hit = '0;
        w_to  = '0;
        for (int i = 0; i < c_ENTRIES; i++) begin
            w_hit[i] = (w_a_fire && (bus.a_id_i == ID_WIDTH'(i))) ||
                       (w_b_fire && (bus.b_id_i == ID_WIDTH'(i)));
            w_to[i]  = r_busy[i] && !w_hit[i] && (r_age[i] == c_AGE_LAST);
        end
    end

    // Next occupancy: hit entries stay busy only if a new result is stored.
    always_comb begin
        w_busy_nxt = '0;
        for (int i = 0; i < c_ENTRIES; i++) begin
            if (w_hit[i]) begin
                w_busy_nxt[i] = (w_wr_a && (bus.a_id_i == ID_WIDTH'(i))) ||
                                (w_wr_b && (bus.b_id_i == ID_WIDTH'(i)));
            end else begin
                w_busy_nxt[i] = r_busy[i] && !w_to[i];
            end
        end
    end

    // Population counts of expiring entries and of next-cycle occupancy.
    always_comb begin
        w_to_cnt   = '0;
        w_pend_nxt = '0;
        for (int i = 0; i < c_ENTRIES; i++) begin
            w_to_cnt   = w_to_cnt   + (ID_WIDTH + 1)'(w_to[i]);
            w_pend_nxt = w_pend_nxt + (ID_WIDTH + 1)'(w_busy_nxt[i]);
        end
    end

    // Entry payload and age; occupancy itself lives with the status registers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < c_ENTRIES; i++) begin
                if (w_wr_a && (bus.a_id_i == ID_WIDTH'(i))) begin
                    r_side[i] <= c_SIDE_A;
                    r_we[i]   <= bus.a_we_i;
                    r_rd[i]   <= bus.a_rd_i;
                    r_data[i] <= bus.a_data_i;
                    r_age[i]  <= c_AGE_FIRST;
                end else if (w_wr_b && (bus.b_id_i == ID_WIDTH'(i))) begin
                    r_side[i] <= c_SIDE_B;
                    r_we[i]   <= bus.b_we_i;
                    r_rd[i]   <= bus.b_rd_i;
                    r_data[i] <= bus.b_data_i;
                    r_age[i]  <= c_AGE_FIRST;
                end else if (r_busy[i] && !w_hit[i] && !w_to[i]) begin
                    r_age[i]  <= r_age[i] + c_AGE_W'(1);
                end
            end
        end
    end

    // Occupancy, event pulses, sticky error and saturating statistics.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_busy         <= '0;
            r_mismatch     <= 1'b0;
            r_mismatch_id  <= '0;
            r_dup          <= 1'b0;
            r_timeout      <= 1'b0;
            r_err          <= 1'b0;
            r_match_cnt    <= '0;
            r_mismatch_cnt <= '0;
            r_timeout_cnt  <= '0;
            r_pending      <= '0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_mismatch <= w_mm_a | w_mm_b;
            if (w_mm_a) begin
                r_mismatch_id <= bus.a_id_i;
            end else if (w_mm_b) begin
                r_mismatch_id <= bus.b_id_i;
            end
            r_dup          <= w_dup_a | w_dup_b;
            r_timeout      <= |w_to;
            r_err          <= r_err | w_mm_a | w_mm_b | w_dup_a | w_dup_b | (|w_to);
            r_match_cnt    <= sat_add(r_match_cnt, (ID_WIDTH + 1)'(w_match_inc));
            r_mismatch_cnt <= sat_add(r_mismatch_cnt, (ID_WIDTH + 1)'(w_mismatch_inc));
            r_timeout_cnt  <= sat_add(r_timeout_cnt, w_to_cnt);
            r_pending      <= w_pend_nxt;
        end
    end

    assign bus.mismatch_o     = r_mismatch;
    assign bus.mismatch_id_o  = r_mismatch_id;
    assign bus.dup_err_o      = r_dup;
    assign bus.timeout_o      = r_timeout;
    assign bus.err_o          = r_err;
    assign bus.match_cnt_o    = r_match_cnt;
    assign bus.mismatch_cnt_o = r_mismatch_cnt;
    assign bus.timeout_cnt_o  = r_timeout_cnt;
    assign bus.pending_o      = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_xif_result_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_xif_result_scoreboard
// Description : Self-checking bench for xif_result_scoreboard: directed vector
//               table, hand-written timeout/duplicate/reset sequences, and a
//               randomized run against a pending-map reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xif_result_scoreboard;

    localparam int IDW  = 4;
    localparam int DW   = 32;
    localparam int TO   = 8;
    localparam int CW   = 6;
    localparam int N    = 16;
    localparam int CMAX = 63;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    xif_result_scoreboard_if #(.ID_WIDTH(IDW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    xif_result_scoreboard #(
        .ID_WIDTH   (IDW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int nchecks = 0;
    int nerrors = 0;

    // ---------------- reference model: pending map with absolute deadlines ----
    bit          m_busy [N];
    bit          m_side [N];   // 0 = A, 1 = B
    bit          m_we   [N];
    int          m_rd   [N];
    logic [31:0] m_data [N];
    int          m_dead [N];
    int          cyc = 0;

    bit e_mm, e_dup, e_to, e_err;
    int e_mmid, e_mc, e_mmc, e_tc, e_pend;

    function automatic bit agree(bit we1, int rd1, logic [31:0] d1, bit we2, int rd2, logic [31:0] d2);
        return (we1 == we2) && (!we1 || ((rd1 == rd2) && (d1 == d2)));
    endfunction

    task automatic put(int id, bit side, bit we, int rd, logic [31:0] d);
        m_busy[id] = 1'b1;
        m_side[id] = side;
        m_we[id]   = we;
        m_rd[id]   = rd;
        m_data[id] = d;
        m_dead[id] = cyc + TO - 1;
    endtask

    function automatic int sat(int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic model_step();
        bit ta, tb2, mm_a, mm_b, dup, ok;
        bit hit [N];
        int nm, nmm, nto, aid, bid, ard, brd;
        bit awe, bwe;
        logic [31:0] ad, bd;
        ta  = bus.a_valid_i && bus.a_ready_i;
        tb2 = bus.b_valid_i && bus.b_ready_i;
        aid = int'(bus.a_id_i); awe = bus.a_we_i; ard = int'(bus.a_rd_i); ad = bus.a_data_i;
        bid = int'(bus.b_id_i); bwe = bus.b_we_i; brd = int'(bus.b_rd_i); bd = bus.b_data_i;
        mm_a = 0; mm_b = 0; dup = 0; nm = 0; nmm = 0; nto = 0;
        for (int i = 0; i < N; i++) hit[i] = 0;
        if (rst) begin
            for (int i = 0; i < N; i++) m_busy[i] = 0;
            e_mm = 0; e_dup = 0; e_to = 0; e_err = 0;
            e_mmid = 0; e_mc = 0; e_mmc = 0; e_tc = 0; e_pend = 0;
        end else begin
            if (ta && tb2 && aid == bid) begin
                hit[aid] = 1;
                if (!m_busy[aid]) begin
                    ok = agree(awe, ard, ad, bwe, brd, bd);
                    if (ok) nm++; else begin nmm++; mm_a = 1; end
                end else if (m_side[aid] == 0) begin
                    ok = agree(m_we[aid], m_rd[aid], m_data[aid], bwe, brd, bd);
                    if (ok) nm++; else begin nmm++; mm_b = 1; end
                    put(aid, 0, awe, ard, ad);
                end else begin
                    ok = agree(m_we[aid], m_rd[aid], m_data[aid], awe, ard, ad);
                    if (ok) nm++; else begin nmm++; mm_a = 1; end
                    put(aid, 1, bwe, brd, bd);
                end
            end else begin
                if (ta) begin
                    hit[aid] = 1;
                    if (!m_busy[aid]) put(aid, 0, awe, ard, ad);
                    else if (m_side[aid] == 1) begin
                        ok = agree(m_we[aid], m_rd[aid], m_data[aid], awe, ard, ad);
                        if (ok) nm++; else begin nmm++; mm_a = 1; end
                        m_busy[aid] = 0;
                    end else begin
                        dup = 1;
                        put(aid, 0, awe, ard, ad);
                    end
                end
                if (tb2) begin
                    hit[bid] = 1;
                    if (!m_busy[bid]) put(bid, 1, bwe, brd, bd);
                    else if (m_side[bid] == 0) begin
                        ok = agree(m_we[bid], m_rd[bid], m_data[bid], bwe, brd, bd);
                        if (ok) nm++; else begin nmm++; mm_b = 1; end
                        m_busy[bid] = 0;
                    end else begin
                        dup = 1;
                        put(bid, 1, bwe, brd, bd);
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                if (m_busy[i] && !hit[i] && m_dead[i] == cyc) begin
                    m_busy[i] = 0;
                    nto++;
                end
            end
            e_mm  = mm_a || mm_b;
            if (mm_a) e_mmid = aid;
            else if (mm_b) e_mmid = bid;
            e_dup = dup;
            e_to  = (nto > 0);
            e_err = e_err || e_mm || dup || e_to;
            e_mc  = sat(e_mc + nm);
            e_mmc = sat(e_mmc + nmm);
            e_tc  = sat(e_tc + nto);
            e_pend = 0;
            for (int i = 0; i < N; i++) e_pend += int'(m_busy[i]);
        end
        cyc++;
    endtask

    // ---------------- stimulus helpers ----------------------------------------
    task automatic set_a(bit v, bit r, int id, bit we, int rd, logic [31:0] d);
        bus.a_valid_i = v; bus.a_ready_i = r; bus.a_id_i = IDW'(id);
        bus.a_we_i = we; bus.a_rd_i = 5'(rd); bus.a_data_i = d;
    endtask

    task automatic set_b(bit v, bit r, int id, bit we, int rd, logic [31:0] d);
        bus.b_valid_i = v; bus.b_ready_i = r; bus.b_id_i = IDW'(id);
        bus.b_we_i = we; bus.b_rd_i = 5'(rd); bus.b_data_i = d;
    endtask

    task automatic idle();
        set_a(0, 0, 0, 0, 0, 32'h0);
        set_b(0, 0, 0, 0, 0, 32'h0);
    endtask

    // One clock: model consumes this cycle's inputs, outputs sampled 1ns after the edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("rnd_mismatch",     32'(bus.mismatch_o),     32'(e_mm));
        chk("rnd_mismatch_id",  32'(bus.mismatch_id_o),  32'(e_mmid));
        chk("rnd_dup",          32'(bus.dup_err_o),      32'(e_dup));
        chk("rnd_timeout",      32'(bus.timeout_o),      32'(e_to));
        chk("rnd_err",          32'(bus.err_o),          32'(e_err));
        chk("rnd_match_cnt",    32'(bus.match_cnt_o),    32'(e_mc));
        chk("rnd_mismatch_cnt", 32'(bus.mismatch_cnt_o), 32'(e_mmc));
        chk("rnd_timeout_cnt",  32'(bus.timeout_cnt_o),  32'(e_tc));
        chk("rnd_pending",      32'(bus.pending_o),      32'(e_pend));
    endtask

    // ---------------- directed vector table -----------------------------------
    typedef struct {
        bit av; bit ar; int aid; bit awe; int ard; logic [31:0] ad;
        bit bv; bit br; int bid; bit bwe; int brd; logic [31:0] bd;
        bit e_mm; int e_mmid; bit e_dup; bit e_err; int e_mc; int e_pend;
    } vec_t;

    function automatic vec_t mkv(bit av, int aid, int ard, logic [31:0] ad,
                                 bit bv, int bid, int brd, logic [31:0] bd,
                                 bit mm, int mmid, bit dup, bit err, int mc, int pend);
        vec_t v;
        v.av = av; v.ar = av; v.aid = aid; v.awe = 1; v.ard = ard; v.ad = ad;
        v.bv = bv; v.br = bv; v.bid = bid; v.bwe = 1; v.brd = brd; v.bd = bd;
        v.e_mm = mm; v.e_mmid = mmid; v.e_dup = dup; v.e_err = err; v.e_mc = mc; v.e_pend = pend;
        return v;
    endfunction

    vec_t tbl [13];

    initial begin
        //             A: v id rd data          B: v id rd data           mm id dup err mc pend
        tbl[0]  = mkv(1, 3, 5, 32'h3F800000, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 1);
        tbl[1]  = mkv(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 1);
        tbl[2]  = mkv(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 1);
        tbl[3]  = mkv(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 1);
        tbl[4]  = mkv(0, 0, 0, 32'h0,        1, 3, 5, 32'h3F800000,   0, 0, 0, 0, 1, 0);
        tbl[5]  = mkv(1, 2, 1, 32'h40000000, 1, 2, 1, 32'h40000001,   1, 2, 0, 1, 1, 0);
        tbl[6]  = mkv(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,          0, 2, 0, 1, 1, 0);
        tbl[7]  = mkv(1, 1, 2, 32'h11,       0, 0, 0, 32'h0,          0, 2, 0, 1, 1, 1);
        tbl[8]  = mkv(1, 2, 3, 32'h22,       0, 0, 0, 32'h0,          0, 2, 0, 1, 1, 2);
        tbl[9]  = mkv(1, 3, 4, 32'h33,       0, 0, 0, 32'h0,          0, 2, 0, 1, 1, 3);
        tbl[10] = mkv(0, 0, 0, 32'h0,        1, 3, 4, 32'h33,         0, 2, 0, 1, 2, 2);
        tbl[11] = mkv(0, 0, 0, 32'h0,        1, 1, 2, 32'h11,         0, 2, 0, 1, 3, 1);
        tbl[12] = mkv(0, 0, 0, 32'h0,        1, 2, 3, 32'h22,         0, 2, 0, 1, 4, 0);

        idle();
        #1;
        do_reset();

        // Reset state
        chk("reset_mismatch",    32'(bus.mismatch_o),     32'd0);
        chk("reset_mismatch_id", 32'(bus.mismatch_id_o),  32'd0);
        chk("reset_err",         32'(bus.err_o),          32'd0);
        chk("reset_match_cnt",   32'(bus.match_cnt_o),    32'd0);
        chk("reset_pending",     32'(bus.pending_o),      32'd0);

        // In-order match, same-cycle mismatch, out-of-order matches
        for (int k = 0; k < 13; k++) begin
            set_a(tbl[k].av, tbl[k].ar, tbl[k].aid, tbl[k].awe, tbl[k].ard, tbl[k].ad);
            set_b(tbl[k].bv, tbl[k].br, tbl[k].bid, tbl[k].bwe, tbl[k].brd, tbl[k].bd);
            tick();
            chk($sformatf("vec%0d_mismatch", k),    32'(bus.mismatch_o),    32'(tbl[k].e_mm));
            chk($sformatf("vec%0d_mismatch_id", k), 32'(bus.mismatch_id_o), 32'(tbl[k].e_mmid));
            chk($sformatf("vec%0d_dup", k),         32'(bus.dup_err_o),     32'(tbl[k].e_dup));
            chk($sformatf("vec%0d_err", k),         32'(bus.err_o),         32'(tbl[k].e_err));
            chk($sformatf("vec%0d_match_cnt", k),   32'(bus.match_cnt_o),   32'(tbl[k].e_mc));
            chk($sformatf("vec%0d_pending", k),     32'(bus.pending_o),     32'(tbl[k].e_pend));
        end

        // Duplicate from the same side
        do_reset();
        set_a(1, 1, 7, 1, 7, 32'h1234); idle_b_keep();
        tick();
        chk("dup_first_pending", 32'(bus.pending_o), 32'd1);
        chk("dup_first_flag",    32'(bus.dup_err_o), 32'd0);
        tick();
        chk("dup_second_flag",    32'(bus.dup_err_o), 32'd1);
        chk("dup_second_pending", 32'(bus.pending_o), 32'd1);
        idle();
        tick();
        chk("dup_after_flag",    32'(bus.dup_err_o), 32'd0);
        chk("dup_after_pending", 32'(bus.pending_o), 32'd1);

        // Timeout exactly TO cycles after capture
        do_reset();
        set_a(1, 1, 4, 1, 4, 32'hAAAA);
        tick();
        idle();
        for (int j = 1; j <= 8; j++) begin
            tick();
            chk($sformatf("to_wait%0d_timeout", j), 32'(bus.timeout_o), 32'(j == 7));
            if (j == 7) begin
                chk("to_timeout_cnt", 32'(bus.timeout_cnt_o), 32'd1);
                chk("to_pending",     32'(bus.pending_o),     32'd0);
            end
        end

        // Partner arriving in the expiry cycle wins over the timeout
        set_a(1, 1, 4, 1, 4, 32'hBBBB);
        tick();
        idle();
        for (int j = 1; j <= 6; j++) begin
            tick();
            chk($sformatf("late_wait%0d_timeout", j), 32'(bus.timeout_o), 32'd0);
        end
        set_b(1, 1, 4, 1, 4, 32'hBBBB);
        tick();
        idle();
        chk("late_timeout",     32'(bus.timeout_o),     32'd0);
        chk("late_match_cnt",   32'(bus.match_cnt_o),   32'd1);
        chk("late_timeout_cnt", 32'(bus.timeout_cnt_o), 32'd1);
        chk("late_pending",     32'(bus.pending_o),     32'd0);
        tick();
        chk("late_after_timeout", 32'(bus.timeout_o), 32'd0);

        // Valid without ready is ignored; reset drops pending entries silently
        do_reset();
        set_a(1, 1, 9, 1, 1, 32'h5);
        set_b(1, 1, 9, 1, 1, 32'h6);
        tick();
        chk("rstseq_err_set", 32'(bus.err_o), 32'd1);
        idle();
        set_a(1, 0, 5, 1, 2, 32'h77);
        for (int j = 0; j < 10; j++) begin
            tick();
            chk($sformatf("noready%0d_pending", j), 32'(bus.pending_o), 32'd0);
        end
        set_a(1, 1, 1, 1, 1, 32'h1);
        tick();
        set_a(1, 1, 2, 1, 2, 32'h2);
        tick();
        chk("rstseq_pending_2", 32'(bus.pending_o), 32'd2);
        rst = 1'b1;
        set_a(1, 1, 3, 1, 3, 32'h3);
        tick();
        rst = 1'b0;
        idle();
        chk("rstseq_pending",      32'(bus.pending_o),      32'd0);
        chk("rstseq_match_cnt",    32'(bus.match_cnt_o),    32'd0);
        chk("rstseq_mismatch_cnt", 32'(bus.mismatch_cnt_o), 32'd0);
        chk("rstseq_timeout_cnt",  32'(bus.timeout_cnt_o),  32'd0);
        chk("rstseq_err",          32'(bus.err_o),          32'd0);
        chk("rstseq_mismatch_id",  32'(bus.mismatch_id_o),  32'd0);
        for (int j = 0; j < 10; j++) begin
            tick();
            chk($sformatf("rstseq_quiet%0d_timeout", j), 32'(bus.timeout_o), 32'd0);
            chk($sformatf("rstseq_quiet%0d_pending", j), 32'(bus.pending_o), 32'd0);
        end

        // Randomized traffic against the reference model
        do_reset();
        check_model();
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 599) == 0);
            set_a($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 80,
                  ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2),
                  $urandom_range(0, 1) ? 32'h3F800000 : 32'h3F800001);
            set_b($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 80,
                  ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2),
                  $urandom_range(0, 1) ? 32'h3F800000 : 32'h3F800001);
            tick();
            check_model();
        end
        rst = 1'b0;
        idle();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

    // Keeps side B quiet while side A is being exercised.
    task automatic idle_b_keep();
        set_b(0, 0, 0, 0, 0, 32'h0);
    endtask

endmodule
`default_nettype wire
